// File: rtl/uart_fifo_tx_if.sv
// FIFO read-side and serial-line signals of uart_fifo_tx.
// master: transmitter side, slave: FIFO/pin side.
interface uart_fifo_tx_if #(
  parameter int unsigned SIZE = 7
);
  logic          enable;
  logic [SIZE:0] fifoData;
  logic          fifoEmpty;
  logic          fifoGet;
  logic          txd;
  logic          busy;

  modport master (
    input  enable,
    input  fifoData,
    input  fifoEmpty,
    output fifoGet,
    output txd,
    output busy
  );

  modport slave (
    output enable,
    output fifoData,
    output fifoEmpty,
    input  fifoGet,
    input  txd,
    input  busy
  );
endinterface

// File: rtl/uart_fifo_tx.sv
// UART transmitter draining a byte FIFO: 8N1 frames, or 8E1 when UART_TX_PARITY_EN is defined.
// All outputs are registered from next-state values, so no input reaches an output combinationally.
module uart_fifo_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SIZE         = 7
) (
  input  logic           clk,
  input  logic           reset,
  uart_fifo_tx_if.master bus
);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (SIZE > 0) ? $clog2(SIZE + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(SIZE);

  typedef enum logic [2:0] {
    StIdle,
    StGet,
    StLatch,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [SIZE:0]   shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            get_q, get_d;
  logic            busy_q, busy_d;
  logic            bit_end;
  logic            timed;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    bit_end = (cnt_q == CntLast);
    timed   = (state_q != StIdle) && (state_q != StGet) && (state_q != StLatch);

    case (state_q)
      StIdle:  if (bus.enable && !bus.fifoEmpty) state_d = StGet;
      StGet:   state_d = StLatch;
      StLatch: begin
        shift_d = bus.fifoData;
`ifdef UART_TX_PARITY_EN
        parity_d = 1'b0;
`endif
        state_d = StStart;
      end
      StStart: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
          parity_d = parity_q ^ shift_q[0];
`endif
          if (idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: if (bit_end) state_d = StStop;
`endif
      StStop:  if (bit_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Every bit boundary and every state entry restarts the baud count at zero.
    cnt_d = (timed && !bit_end) ? cnt_q + 1'b1 : '0;

    case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: txd_d = parity_d;
`endif
      default:  txd_d = 1'b1;
    endcase
    get_d  = (state_d == StGet);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      get_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      get_q   <= get_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.txd     = txd_q;
  assign bus.fifoGet = get_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: FIFO model, line-decoding monitor and a scoreboard of expected frames.
module tb_uart_fifo_tx;
  localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  localparam int FrameLen = FrameBits * CPB;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_fifo_tx_if #(.SIZE(7)) bus ();

  uart_fifo_tx #(
    .CLKS_PER_BIT(CPB),
    .SIZE        (7)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] fq[$];     // bytes waiting in the modelled FIFO
  logic [7:0] exp_q[$];  // bytes expected on the line, in order
  int         starts[$]; // cycle of every observed start bit

  int   get_cnt      = 0;
  int   last_get_cyc = 0;
  logic get_prev     = 1'b0;
  logic pend         = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  function automatic logic [FrameBits-1:0] frame_of(input logic [7:0] b);
    logic [FrameBits-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
    bus.fifoEmpty = 1'b0;
  endtask

  // FIFO read side: a rising get pops, and the popped byte appears on the following cycle.
  initial begin : fifo_model
    forever begin
      @(negedge clk);
      if (pend) begin
        if (fq.size() > 0) bus.fifoData = fq.pop_front();
        pend = 1'b0;
      end
      if (bus.fifoGet === 1'b1) begin
        check("get_single_cycle", {31'd0, get_prev}, 32'd0);
        if (!get_prev) begin
          if (get_cnt > 0) check("get_spacing", {31'd0, (cyc - last_get_cyc >= 5)}, 32'd1);
          get_cnt++;
          last_get_cyc = cyc;
          pend = 1'b1;
        end
      end
      get_prev = bus.fifoGet;
      bus.fifoEmpty = (fq.size() == 0);
    end
  end

  task automatic capture_frame();
    logic [FrameBits-1:0] got;
    logic [FrameBits-1:0] exp_f;
    logic smp;
    got = '0;
    starts.push_back(cyc);
    for (int k = 0; k < FrameBits; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (reset) return;
        smp = bus.txd;
        if (c == 0) got[k] = smp;
        else if (smp !== got[k]) got[k] = 1'bx;
      end
    end
    if (exp_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL frame_unexpected: got %b, required no frame", got);
    end else begin
      exp_f = frame_of(exp_q.pop_front());
      check("frame", 32'(got), 32'(exp_f));
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset && bus.txd === 1'b0) capture_frame();
    end
  end

  task automatic wait_start(output int sc);
    int n0;
    n0 = starts.size();
    sc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (starts.size() > n0) begin
        sc = starts[n0];
        break;
      end
    end
    if (sc < 0) begin
      chk_cnt++;
      $display("FAIL start_timeout: got no start bit, required one within 300 cycles");
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (fq.size() == 0 && exp_q.size() == 0 && bus.busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      chk_cnt++;
      $display("FAIL %s_drain: got %0d bytes pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_gaps(input string name, input int n0, input int nframes);
    if (starts.size() < n0 + nframes) begin
      chk_cnt++;
      $display("FAIL %s: got %0d frames, required %0d", name, starts.size() - n0, nframes);
    end else begin
      for (int i = 1; i < nframes; i++)
        check(name, starts[n0+i] - starts[n0+i-1], FrameLen + 3);
    end
  endtask

  initial begin : main
    int sc, n, n0, g0;
    bus.enable    = 1'b1;
    bus.fifoEmpty = 1'b1;
    bus.fifoData  = '0;
    reset         = 1'b1;

    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_outputs", {29'd0, bus.txd, bus.fifoGet, bus.busy}, 32'b100);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: pulse timing, start latency and line pattern.
    push(8'hA5);
    n = cyc;
    wait_start(sc);
    check("start_latency", sc, n + 3);
    check("get_cycle", last_get_cyc, n + 1);
    wait_drain("a5");
    check("idle_after_frame", {30'd0, bus.busy, bus.fifoEmpty}, 32'b01);

    // Back-to-back bytes.
    @(negedge clk);
    n0 = starts.size();
    g0 = get_cnt;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_drain("b2b");
    check_gaps("b2b_gap", n0, 3);
    check("b2b_gets", get_cnt - g0, 3);

    // Parity-bearing patterns (frame length includes the parity bit when compiled in).
    @(negedge clk);
    n0 = starts.size();
    push(8'h07);
    push(8'h03);
    wait_drain("par");
    check_gaps("par_frame_len", n0, 2);

    // Enable dropped mid-frame.
    @(negedge clk);
    push(8'h55);
    push(8'h66);
    wait_start(sc);
    repeat (CPB + 2) @(negedge clk);
    bus.enable = 1'b0;
    g0 = get_cnt;
    repeat (FrameLen + 30) @(negedge clk);
    check("no_get_disabled", get_cnt, g0);
    check("busy_disabled", {31'd0, bus.busy}, 32'd0);
    check("fifo_kept", {31'd0, bus.fifoEmpty}, 32'd0);
    bus.enable = 1'b1;
    n = cyc;
    wait_start(sc);
    check("reenable_latency", sc, n + 3);
    wait_drain("enable");

    // Reset during data bit 3.
    @(negedge clk);
    push(8'hFF);
    wait_start(sc);
    push(8'h11);
    repeat (16) @(negedge clk);
    reset = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    check("reset_midframe", {29'd0, bus.txd, bus.fifoGet, bus.busy}, 32'b100);
    @(negedge clk);
    reset = 1'b0;
    wait_drain("reset");

    // Random bytes with random spacing.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      repeat ($urandom_range(0, 60)) @(negedge clk);
      push(8'($urandom));
    end
    wait_drain("random");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
